// File: rtl/alu_mdu.sv
// Execute-stage ALU with RV32M multiply/divide behind a valid/ready handshake.
// Base and multiply ops take one cycle; DIV/REM use an iterative restoring divider.
//
//   state  | meaning
//   S_IDLE | waiting for an op; fast ops complete here
//   S_DIV  | restoring divide, one quotient bit per cycle (XLEN cycles)
//   S_FIX  | apply result signs, load the output register
module alu_mdu #(
   parameter int XLEN = 32
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic            flush,
   input  logic            in_valid,
   output logic            in_ready,
   input  logic [4:0]      alu_control,
   input  logic [XLEN-1:0] A,
   input  logic [XLEN-1:0] B,
   output logic            out_valid,
   input  logic            out_ready,
   output logic [XLEN-1:0] result,
   output logic            equal,
   output logic            less_than,
   output logic            less_than_unsigned
);
   localparam int SW = $clog2(XLEN);
   localparam logic [XLEN-1:0] MOST_NEG = {1'b1, {(XLEN-1){1'b0}}};

   typedef enum logic [1:0] {S_IDLE, S_DIV, S_FIX} state_t;
   state_t state_q, state_d;

   logic            accept, op_div, div_signed, div_rem, b_zero, div_ovf;
   logic            div_iter, start_div, take_fast;
   logic [SW-1:0]   shamt;
   logic            eq_c, lt_c, ltu_c;
   logic [XLEN-1:0] fast_res;
   logic            mul_a_sx, mul_b_sx;
   logic [2*XLEN-1:0] mul_a, mul_b, prod;
   logic [XLEN-1:0] a_mag, b_mag;

   logic [XLEN-1:0] quo_q, rem_q, dvsr_q;
   logic [SW-1:0]   cnt_q;
   logic            neg_quo_q, neg_rem_q, is_rem_q;
   logic            eq_p, lt_p, ltu_p;
   logic [XLEN:0]   shifted, diff;
   logic [XLEN-1:0] quo_fix, rem_fix;

   assign in_ready   = (state_q == S_IDLE) && (!out_valid || out_ready) && !flush;
   assign accept     = in_valid && in_ready;

   assign op_div     = (alu_control >= 5'd14) && (alu_control <= 5'd17);
   assign div_signed = (alu_control == 5'd14) || (alu_control == 5'd16);
   assign div_rem    = (alu_control == 5'd16) || (alu_control == 5'd17);
   assign b_zero     = (B == '0);
   assign div_ovf    = div_signed && (A == MOST_NEG) && (B == '1);
   assign div_iter   = op_div && !b_zero && !div_ovf;
   assign start_div  = accept && div_iter;
   assign take_fast  = accept && !div_iter;

   assign shamt = B[SW-1:0];
   assign eq_c  = (A == B);
   assign lt_c  = ($signed(A) < $signed(B));
   assign ltu_c = (A < B);

   // One shared 2*XLEN multiplier; operand extension selects the signedness.
   assign mul_a_sx = (alu_control == 5'd11) || (alu_control == 5'd12);
   assign mul_b_sx = (alu_control == 5'd11);
   assign mul_a    = mul_a_sx ? {{XLEN{A[XLEN-1]}}, A} : {{XLEN{1'b0}}, A};
   assign mul_b    = mul_b_sx ? {{XLEN{B[XLEN-1]}}, B} : {{XLEN{1'b0}}, B};
   assign prod     = mul_a * mul_b;

   assign a_mag = (div_signed && A[XLEN-1]) ? -A : A;
   assign b_mag = (div_signed && B[XLEN-1]) ? -B : B;

   // Divide-by-zero and signed-overflow corners resolve here in one cycle.
   always_comb begin
      fast_res = '0;
      case (alu_control)
         5'd0:  fast_res = A + B;
         5'd1:  fast_res = A - B;
         5'd2:  fast_res = A ^ B;
         5'd3:  fast_res = A | B;
         5'd4:  fast_res = A & B;
         5'd5:  fast_res = A << shamt;
         5'd6:  fast_res = A >> shamt;
         5'd7:  fast_res = $unsigned($signed(A) >>> shamt);
         5'd8:  fast_res = {{(XLEN-1){1'b0}}, lt_c};
         5'd9:  fast_res = {{(XLEN-1){1'b0}}, ltu_c};
         5'd10: fast_res = prod[XLEN-1:0];
         5'd11, 5'd12, 5'd13: fast_res = prod[2*XLEN-1:XLEN];
         5'd14, 5'd15: fast_res = b_zero ? '1 : A;
         5'd16, 5'd17: fast_res = b_zero ? A : '0;
         default: fast_res = '0;
      endcase
   end

   assign shifted = {rem_q, quo_q[XLEN-1]};
   assign diff    = shifted - {1'b0, dvsr_q};
   assign quo_fix = neg_quo_q ? -quo_q : quo_q;
   assign rem_fix = neg_rem_q ? -rem_q : rem_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state_q <= S_IDLE;
      else        state_q <= state_d;
   end

   always_comb begin
      state_d = state_q;
      if (flush) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE:  if (start_div) state_d = S_DIV;
            S_DIV:   if (cnt_q == '0) state_d = S_FIX;
            S_FIX:   state_d = S_IDLE;
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_valid          <= 1'b0;
         result             <= '0;
         equal              <= 1'b0;
         less_than          <= 1'b0;
         less_than_unsigned <= 1'b0;
         quo_q              <= '0;
         rem_q              <= '0;
         dvsr_q             <= '0;
         cnt_q              <= '0;
         neg_quo_q          <= 1'b0;
         neg_rem_q          <= 1'b0;
         is_rem_q           <= 1'b0;
         eq_p               <= 1'b0;
         lt_p               <= 1'b0;
         ltu_p              <= 1'b0;
      end else if (flush) begin
         out_valid <= 1'b0;
      end else if (take_fast) begin
         out_valid          <= 1'b1;
         result             <= fast_res;
         equal              <= eq_c;
         less_than          <= lt_c;
         less_than_unsigned <= ltu_c;
      end else if (start_div) begin
         out_valid <= 1'b0;
         quo_q     <= a_mag;
         rem_q     <= '0;
         dvsr_q    <= b_mag;
         cnt_q     <= SW'(XLEN-1);
         neg_quo_q <= div_signed && (A[XLEN-1] ^ B[XLEN-1]);
         neg_rem_q <= div_signed && A[XLEN-1];
         is_rem_q  <= div_rem;
         eq_p      <= eq_c;
         lt_p      <= lt_c;
         ltu_p     <= ltu_c;
      end else if (state_q == S_DIV) begin
         cnt_q <= cnt_q - 1'b1;
         if (!diff[XLEN]) begin
            rem_q <= diff[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b1};
         end else begin
            rem_q <= shifted[XLEN-1:0];
            quo_q <= {quo_q[XLEN-2:0], 1'b0};
         end
      end else if (state_q == S_FIX) begin
         out_valid          <= 1'b1;
         result             <= is_rem_q ? rem_fix : quo_fix;
         equal              <= eq_p;
         less_than          <= lt_p;
         less_than_unsigned <= ltu_p;
      end else if (out_valid && out_ready) begin
         out_valid <= 1'b0;
      end
   end
endmodule

// File: tb/tb_alu_mdu.sv
// Bench for alu_mdu: vector table through a result scoreboard, plus
// handshake, divide-latency, flush and mid-divide reset sequences.
module tb_alu_mdu;
   localparam int XLEN = 32;

   typedef struct {
      logic [4:0]      op;
      logic [XLEN-1:0] a;
      logic [XLEN-1:0] b;
      logic [XLEN-1:0] res;
   } vec_t;

   typedef struct {
      logic [XLEN-1:0] res;
      logic            eq;
      logic            lt;
      logic            ltu;
      int              id;
   } exp_t;

   logic            clk = 1'b0;
   logic            rst_n = 1'b0;
   logic            flush = 1'b0;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [4:0]      alu_control = '0;
   logic [XLEN-1:0] A = '0;
   logic [XLEN-1:0] B = '0;
   logic            out_valid;
   logic            out_ready = 1'b1;
   logic [XLEN-1:0] result;
   logic            equal, less_than, less_than_unsigned;

   exp_t exp_q[$];
   exp_t mon_e;
   vec_t vecs[$];
   int   n_tests = 0;
   int   n_fail  = 0;
   int   n_out   = 0;

   alu_mdu #(.XLEN(XLEN)) dut (
      .clk(clk), .rst_n(rst_n), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .alu_control(alu_control),
      .A(A), .B(B), .out_valid(out_valid), .out_ready(out_ready),
      .result(result), .equal(equal), .less_than(less_than),
      .less_than_unsigned(less_than_unsigned)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [XLEN-1:0] act, input logic [XLEN-1:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst_n && out_valid && out_ready) begin
         n_out++;
         if (exp_q.size() == 0) begin
            n_tests++;
            n_fail++;
            $display("FAIL unexpected_result: got %h, expected no result", result);
         end else begin
            mon_e = exp_q.pop_front();
            check($sformatf("result[%0d]", mon_e.id), result, mon_e.res);
            check($sformatf("flags[%0d]", mon_e.id),
                  XLEN'({equal, less_than, less_than_unsigned}),
                  XLEN'({mon_e.eq, mon_e.lt, mon_e.ltu}));
         end
      end
   end

   // Call at posedge+1; returns at posedge+1 after the accepting edge.
   task automatic send(input logic [4:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [XLEN-1:0] res, input int id, output int waits);
      exp_t e;
      waits = 0;
      in_valid = 1'b1; alu_control = op; A = a; B = b;
      @(negedge clk);
      while (!in_ready && waits < 200) begin
         @(negedge clk);
         waits++;
      end
      if (!in_ready) begin
         check($sformatf("accept_timeout[%0d]", id), XLEN'(in_ready), 1);
         @(posedge clk);
      end else begin
         @(posedge clk);
         e.res = res; e.id = id;
         e.eq  = (a == b);
         e.lt  = ($signed(a) < $signed(b));
         e.ltu = (a < b);
         exp_q.push_back(e);
      end
      #1 in_valid = 1'b0;
   endtask

   task automatic drain();
      int g = 0;
      while (exp_q.size() != 0 && g < 200) begin
         @(negedge clk); #1;
         g++;
      end
      if (exp_q.size() != 0) begin
         check("drain_pending", XLEN'(exp_q.size()), 0);
         exp_q.delete();
      end
      @(posedge clk); #1;
   endtask

   function automatic void add_vec(input logic [4:0] op, input logic [XLEN-1:0] a,
                                   input logic [XLEN-1:0] b, input logic [XLEN-1:0] res);
      vec_t v;
      v.op = op; v.a = a; v.b = b; v.res = res;
      vecs.push_back(v);
   endfunction

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish, expected finish");
      $fatal(1, "watchdog");
   end

   initial begin
      int w, tot, n0, lat, lo, seen;
      add_vec(5'd0,  32'h7FFFFFFF, 32'h00000001, 32'h80000000);
      add_vec(5'd1,  32'h00000005, 32'h00000007, 32'hFFFFFFFE);
      add_vec(5'd2,  32'hF0F0F0F0, 32'h0FF00FF0, 32'hFF00FF00);
      add_vec(5'd3,  32'hF0000000, 32'h0000000F, 32'hF000000F);
      add_vec(5'd4,  32'hFF00FF00, 32'h0F0F0F0F, 32'h0F000F00);
      add_vec(5'd5,  32'h00000001, 32'h0000002F, 32'h00008000);
      add_vec(5'd6,  32'h80000000, 32'h00000021, 32'h40000000);
      add_vec(5'd7,  32'h80000000, 32'h00000021, 32'hC0000000);
      add_vec(5'd8,  32'hFFFFFFFF, 32'h00000001, 32'h00000001);
      add_vec(5'd9,  32'h00000001, 32'hFFFFFFFF, 32'h00000001);
      add_vec(5'd10, 32'h00010000, 32'h00010000, 32'h00000000);
      add_vec(5'd10, 32'hFFFFFFFF, 32'h00000003, 32'hFFFFFFFD);
      add_vec(5'd11, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h00000000);
      add_vec(5'd13, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE);
      add_vec(5'd12, 32'hFFFFFFFF, 32'h00000002, 32'hFFFFFFFF);
      add_vec(5'd11, 32'h80000000, 32'h80000000, 32'h40000000);
      add_vec(5'd12, 32'h80000000, 32'h80000000, 32'hC0000000);
      add_vec(5'd15, 32'd100,      32'd7,        32'd14);
      add_vec(5'd17, 32'd100,      32'd7,        32'd2);
      add_vec(5'd14, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFD);
      add_vec(5'd16, 32'hFFFFFFF9, 32'h00000002, 32'hFFFFFFFF);
      add_vec(5'd14, 32'h00000007, 32'hFFFFFFFE, 32'hFFFFFFFD);
      add_vec(5'd16, 32'h00000007, 32'hFFFFFFFE, 32'h00000001);
      add_vec(5'd14, 32'h00000005, 32'h00000000, 32'hFFFFFFFF);
      add_vec(5'd16, 32'h00000005, 32'h00000000, 32'h00000005);
      add_vec(5'd15, 32'h00000005, 32'h00000000, 32'hFFFFFFFF);
      add_vec(5'd17, 32'h00000005, 32'h00000000, 32'h00000005);
      add_vec(5'd14, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      add_vec(5'd16, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
      add_vec(5'd15, 32'h80000000, 32'hFFFFFFFF, 32'h00000000);
      add_vec(5'd17, 32'h80000000, 32'hFFFFFFFF, 32'h80000000);
      add_vec(5'd20, 32'h00000003, 32'h00000004, 32'h00000000);

      // reset state
      repeat (3) @(posedge clk);
      #1;
      check("rst_out_valid", XLEN'(out_valid), 0);
      check("rst_result", result, 0);
      check("rst_flags", XLEN'({equal, less_than, less_than_unsigned}), 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_in_ready", XLEN'(in_ready), 1);
      @(posedge clk); #1;

      foreach (vecs[i]) send(vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].res, i, w);
      drain();

      // single-cycle latency
      send(5'd0, 32'd3, 32'd4, 32'd7, 100, w);
      @(negedge clk);
      check("base_latency_valid", XLEN'(out_valid), 1);
      drain();

      // divide latency and busy window
      send(5'd15, 32'd100, 32'd7, 32'd14, 101, w);
      lat = 0; lo = 0;
      for (int k = 1; k <= 100; k++) begin
         @(negedge clk);
         if (out_valid) begin
            lat = k - 1;
            break;
         end
         if (!in_ready) lo++;
      end
      check("div_edges_to_valid", XLEN'(lat), 33);
      check("div_in_ready_low_cycles", XLEN'(lo), 33);
      drain();

      // output hold under back-pressure
      out_ready = 1'b0;
      send(5'd0, 32'd3, 32'd4, 32'd7, 102, w);
      @(negedge clk);
      check("hold_valid", XLEN'(out_valid), 1);
      for (int k = 0; k < 5; k++) begin
         check("hold_result", result, 32'd7);
         check("hold_in_ready", XLEN'(in_ready), 0);
         @(negedge clk);
      end
      @(posedge clk); #1;
      out_ready = 1'b1;
      send(5'd0, 32'd10, 32'd20, 32'd30, 103, w);
      check("same_edge_accept_waits", XLEN'(w), 0);
      @(negedge clk);
      check("next_result_valid", XLEN'(out_valid), 1);
      check("next_result", result, 32'd30);
      drain();

      // streaming
      n0 = n_out; tot = 0;
      for (int i = 0; i < 10; i++) begin
         send(5'd0, XLEN'(i), 32'd100, XLEN'(i + 100), 200 + i, w);
         tot += w;
      end
      check("stream_stalls", XLEN'(tot), 0);
      @(negedge clk); #1;
      check("stream_results", XLEN'(n_out - n0), 10);
      drain();

      // flush during divu
      send(5'd15, 32'd100, 32'd7, 32'd14, 300, w);
      repeat (9) @(posedge clk);
      #1 flush = 1'b1;
      @(negedge clk);
      check("flush_in_ready", XLEN'(in_ready), 0);
      @(posedge clk); #1 flush = 1'b0;
      exp_q.delete();
      @(negedge clk);
      check("flush_out_valid", XLEN'(out_valid), 0);
      check("flush_in_ready_after", XLEN'(in_ready), 1);
      seen = 0;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("flush_no_result", XLEN'(seen), 0);
      @(posedge clk); #1;
      send(5'd0, 32'd5, 32'd6, 32'd11, 301, w);
      drain();

      // asynchronous reset mid-divide
      send(5'd15, 32'd1000, 32'd3, 32'd333, 400, w);
      repeat (5) @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", XLEN'(out_valid), 0);
      check("async_rst_result", result, 0);
      exp_q.delete();
      @(posedge clk); #1 rst_n = 1'b1;
      @(posedge clk); #1;
      send(5'd0, 32'd20, 32'd22, 32'd42, 401, w);
      drain();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end
endmodule
